// File: rtl/mvu_job_arbiter_if.sv
// Job interface between the pito harts, the arbiter and the MVU command port.
// The master modport is the requester/MVU side; the slave modport is the arbiter.
interface mvu_job_arbiter_if #(
  parameter int NREQ  = 8,
  parameter int CFG_W = 32
);
  localparam int OW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*CFG_W-1:0] cfg;
  logic [NREQ-1:0]       ack;
  logic [NREQ-1:0]       irq;
  logic [NREQ-1:0]       err;
  logic                  mvu_start;
  logic [CFG_W-1:0]      mvu_cfg;
  logic [OW-1:0]         mvu_owner;
  logic                  mvu_done;
  logic                  busy;

  modport master (
    output req, cfg, mvu_done,
    input  ack, irq, err, mvu_start, mvu_cfg, mvu_owner, busy
  );

  modport slave (
    input  req, cfg, mvu_done,
    output ack, irq, err, mvu_start, mvu_cfg, mvu_owner, busy
  );
endinterface

// File: rtl/mvu_job_arbiter.sv
// Round-robin arbiter sharing one MVU command port among NREQ harts.
// One job in flight at a time: grant, single-cycle start, wait for done or
// timeout, then a completion (irq) or error (err) pulse to the owner.
// Every output is a register; next-state logic computes the values the
// outputs take in the following state.
module mvu_job_arbiter #(
  parameter int NREQ    = 8,
  parameter int CFG_W   = 32,
  parameter int TIMEOUT = 4096,
  parameter int TO_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  mvu_job_arbiter_if.slave    bus
);
  localparam int OW = $clog2(NREQ);

  typedef enum logic [1:0] {
    s_idle  = 2'd0,
    s_start = 2'd1,
    s_busy  = 2'd2,
    s_done  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [OW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic [NREQ-1:0]  irq_q, irq_d;
  logic [NREQ-1:0]  err_q, err_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;

  logic             grant_vld;
  logic [OW-1:0]    grant_idx;
  logic [OW-1:0]    scan_idx;

  function automatic logic [NREQ-1:0] onehot(input logic [OW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Rotating priority search: first set req bit from rr_ptr upward, wrapping
  // naturally because NREQ is a power of two.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = rr_ptr_q;
    scan_idx  = rr_ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = rr_ptr_q + OW'(i);
      if (!grant_vld && bus.req[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // Next-state and next-output logic; pulses default low each cycle.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    cfg_d    = cfg_q;
    ack_d    = '0;
    irq_d    = '0;
    err_d    = '0;
    start_d  = 1'b0;
    busy_d   = 1'b0;
    case (state_q)
      s_idle: begin
        if (grant_vld) begin
          state_d = s_start;
          owner_d = grant_idx;
          cfg_d   = bus.cfg[grant_idx*CFG_W +: CFG_W];
          ack_d   = onehot(grant_idx);
          start_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      s_start: begin
        // mvu_done is deliberately not looked at here.
        state_d = s_busy;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
      s_busy: begin
        busy_d = 1'b1;
        cnt_d  = cnt_q + TO_W'(1);
        if (bus.mvu_done) begin
          // Done wins over a coincident timeout.
          state_d = s_done;
          irq_d   = onehot(owner_q);
        end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d = s_done;
          err_d   = onehot(owner_q);
        end
      end
      s_done: begin
        state_d  = s_idle;
        rr_ptr_d = owner_q + OW'(1);
      end
      default: begin
        state_d = s_idle;
      end
    endcase
  end

  // State and output registers; reset drops any job in flight silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= s_idle;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      cfg_q    <= '0;
      ack_q    <= '0;
      irq_q    <= '0;
      err_q    <= '0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      cfg_q    <= cfg_d;
      ack_q    <= ack_d;
      irq_q    <= irq_d;
      err_q    <= err_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.irq       = irq_q;
  assign bus.err       = err_q;
  assign bus.mvu_start = start_q;
  assign bus.mvu_cfg   = cfg_q;
  assign bus.mvu_owner = owner_q;
  assign bus.busy      = busy_q;
endmodule
